div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle divider controller and datapath for DIV/DIVU, sitting beside the EX stage.
- Accepts a divide request from EX and performs a radix-2 restoring division over 32 iterations.
- Raises a stall request to CTRL while busy, so that IF/ID/EX hold.
- Returns a 64-bit {remainder, quotient} result for HI/LO writeback through the MEM/WB path.

Parameters:
- DATA_WD, 32, operand width; the iteration count equals DATA_WD.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  EX holds a DIV/DIVU; EX keeps it high until it sees ready.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1  in  DATA_WD  dividend (rs).
- opdata2  in  DATA_WD  divisor (rt).
- annul  in  1  cancel the operation in progress (flush).
- result  out  2*DATA_WD  {remainder[63:32], quotient[31:0]}; valid only while ready=1.
- ready  out  1  result valid; registered.
- stallreq  out  1  pipeline stall request to CTRL; combinational.
- busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, ZERO, ON, END.
- Reset, asynchronous, any state: state=IDLE, cnt=0, result=0, ready=0, busy=0.
- stallreq = start & ~annul & (state != END). It is therefore high from the IDLE cycle that sees start until the cycle before END.
- IDLE:
  - start & ~annul & opdata2==0 → ZERO.
  - start & ~annul, divisor nonzero → ON.
  - On entry to ON, latch operand magnitudes: |op| when signed_div, raw value otherwise.
  - Also latch the sign flags: quotient negative = sign1 ^ sign2; remainder negative = sign1.
  - Set partial remainder = 0 and cnt = 0.
  - Otherwise stay in IDLE.
- ZERO: one cycle, result=0 → END. Divide by zero is architecturally UNPREDICTABLE; zero is the decided value.
- ON: one quotient bit per cycle.
  - Shift the {rem, dividend} pair left by 1.
  - Trial subtract = rem − divisor using a DATA_WD+1-bit subtractor.
  - If non-negative, rem = difference and shift in 1; else shift in 0.
  - cnt increments each cycle. After the DATA_WD-th iteration (cnt == DATA_WD−1 at the edge), apply sign correction by two's-complement negation where flagged, load result, go to END.
- END:
  - ready=1 and result stable.
  - Stay in END while start=1. This covers EX being held by another stall source, and guarantees no restart on the same instruction.
  - start=0 → IDLE with ready=0.
- annul=1 in ZERO or ON → IDLE next edge; ready stays 0 and result is unchanged.
- annul in END → IDLE.
- annul takes priority over start in every state.
- Latency: start seen in IDLE at cycle T.
  - ON occupies T+1..T+DATA_WD; END and ready=1 at T+DATA_WD+1 (T+33 for 32-bit).
  - Divide by zero: END at T+2.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0. This wraps naturally through magnitude arithmetic and needs no trap.
- A new request is accepted only from IDLE. Back-to-back divides cost one IDLE cycle between them.

Test Plan:
- Unsigned: start, DIVU, 7 / 2 at cycle T → stallreq high T..T+32; ready=1 at T+33 with result {0x00000001, 0x00000003}; stallreq low at T+33.
- Signed: DIV −7 / 2 (0xFFFFFFF9, 0x00000002) → result {0xFFFFFFFF, 0xFFFFFFFD}. Then DIV 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero: DIV 5 / 0 → ZERO at T+1, ready at T+2, result 0; stallreq high for T and T+1 only.
- Annul: raise annul at T+10 of a DIVU → IDLE at T+11; ready never asserts; a fresh DIVU 100 / 7 then gives {2, 14} after the full latency.
- Held start: keep start high 5 cycles after ready → ready and result stay constant, no new operation; drop start → IDLE next edge.
- Reset mid-operation: assert rst asynchronously at T+15 → outputs cleared immediately and state IDLE without waiting for a clock edge. Edge case 0x80000000 / −1 signed → {0x00000000, 0x80000000}.

Source files
------------

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, sitting beside EX.
// Stalls the front of the pipeline while busy and hands {remainder, quotient} to HI/LO writeback.
module div_seq #(
    parameter int DATA_WD = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   signed_div,
    input  logic [DATA_WD-1:0]     opdata1,
    input  logic [DATA_WD-1:0]     opdata2,
    input  logic                   annul,
    output logic [2*DATA_WD-1:0]   result,
    output logic                   ready,
    output logic                   stallreq,
    output logic                   busy
);

    localparam int CNT_WD = $clog2(DATA_WD);

    typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_e;

    state_e                 state_q;
    logic [CNT_WD-1:0]      cnt_q;
    logic [DATA_WD-1:0]     dividend_q;
    logic [DATA_WD-1:0]     divisor_q;
    logic [DATA_WD-1:0]     rem_q;
    logic                   negQuot_q;
    logic                   negRem_q;
    logic [2*DATA_WD-1:0]   result_q;
    logic                   ready_q;

    logic [DATA_WD-1:0]     absOp1;
    logic [DATA_WD-1:0]     absOp2;
    logic [DATA_WD:0]       remShift;
    logic [DATA_WD:0]       trialDiff;
    logic [DATA_WD-1:0]     rem_d;
    logic [DATA_WD-1:0]     quot_d;
    logic [DATA_WD-1:0]     remFinal;
    logic [DATA_WD-1:0]     quotFinal;

    // The shifted partial remainder can need DATA_WD+1 bits, so the trial
    // subtract is one bit wider and its top bit tells us whether it went negative.
    always_comb begin
        absOp1    = (signed_div && opdata1[DATA_WD-1]) ? -opdata1 : opdata1;
        absOp2    = (signed_div && opdata2[DATA_WD-1]) ? -opdata2 : opdata2;
        remShift  = {rem_q, dividend_q[DATA_WD-1]};
        trialDiff = remShift - {1'b0, divisor_q};
        rem_d     = trialDiff[DATA_WD] ? remShift[DATA_WD-1:0] : trialDiff[DATA_WD-1:0];
        quot_d    = {dividend_q[DATA_WD-2:0], ~trialDiff[DATA_WD]};
        remFinal  = negRem_q  ? -rem_d  : rem_d;
        quotFinal = negQuot_q ? -quot_d : quot_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            negQuot_q  <= 1'b0;
            negRem_q   <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (start && !annul) begin
                        if (opdata2 == '0) begin
                            state_q <= ZERO;
                        end else begin
                            state_q    <= ON;
                            dividend_q <= absOp1;
                            divisor_q  <= absOp2;
                            rem_q      <= '0;
                            cnt_q      <= '0;
                            negQuot_q  <= signed_div & (opdata1[DATA_WD-1] ^ opdata2[DATA_WD-1]);
                            negRem_q   <= signed_div & opdata1[DATA_WD-1];
                        end
                    end
                end
                // Divide by zero is architecturally unpredictable; we answer zero.
                ZERO: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end
                end
                ON: begin
                    if (annul) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q      <= rem_d;
                        dividend_q <= quot_d;
                        cnt_q      <= cnt_q + 1'b1;
                        if (cnt_q == CNT_WD'(DATA_WD - 1)) begin
                            result_q <= {remFinal, quotFinal};
                            ready_q  <= 1'b1;
                            state_q  <= END;
                        end
                    end
                end
                // Holding here while start stays high stops the same instruction restarting.
                END: begin
                    if (annul || !start) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result   = result_q;
    assign ready    = ready_q;
    assign busy     = (state_q != IDLE);
    assign stallreq = start & ~annul & (state_q != END);

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: latency, signed/unsigned results,
// divide by zero, annul, held start and asynchronous reset.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    div_seq #(.DATA_WD(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stallreq   (stallreq),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues a request and watches until ready (bounded); start is left high.
    task automatic runDivide(input logic sd, input logic [31:0] a, input logic [31:0] b,
                             output logic [63:0] res, output int readyAt,
                             output bit stallOk, output bit stallLowAtReady);
        @(negedge clk);
        start = 1'b1; signed_div = sd; opdata1 = a; opdata2 = b; annul = 1'b0;
        readyAt = -1; stallOk = 1'b1; stallLowAtReady = 1'b0; res = '0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (ready) begin
                readyAt = k; res = result; stallLowAtReady = !stallreq;
                break;
            end
            if (!stallreq) stallOk = 1'b0;
        end
    endtask

    task automatic releaseStart();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(negedge clk);
        #1;
        assertCount++;
        if (ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready got %b want 0", ready); end
        assertCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        assertCount++;
        if (result !== 64'h0) begin failCount++; $display("[TB] FAIL reset_result got %h want 0", result); end
        assertCount++;
        if (stallreq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stall got %b want 0", stallreq); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [63:0] res; int rdy; bit stOk; bit stLow;
        runDivide(1'b0, 32'd7, 32'd2, res, rdy, stOk, stLow);
        assertCount++;
        if (rdy != 33) begin failCount++; $display("[TB] FAIL divu_latency got %0d want 33", rdy); end
        assertCount++;
        if (res !== 64'h00000001_00000003) begin failCount++; $display("[TB] FAIL divu_result got %h want 0000000100000003", res); end
        assertCount++;
        if (!stOk) begin failCount++; $display("[TB] FAIL divu_stall got low want high T..T+32"); end
        assertCount++;
        if (!stLow) begin failCount++; $display("[TB] FAIL divu_stall_at_ready got high want low"); end
        releaseStart();
    endtask

    task automatic test_signed();
        logic [63:0] res; int rdy; bit stOk; bit stLow;
        runDivide(1'b1, 32'hFFFFFFF9, 32'h00000002, res, rdy, stOk, stLow);
        assertCount++;
        if (rdy != 33) begin failCount++; $display("[TB] FAIL div_neg_latency got %0d want 33", rdy); end
        assertCount++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) begin failCount++; $display("[TB] FAIL div_neg_dividend got %h want FFFFFFFFFFFFFFFD", res); end
        releaseStart();
        runDivide(1'b1, 32'h00000007, 32'hFFFFFFFE, res, rdy, stOk, stLow);
        assertCount++;
        if (rdy != 33) begin failCount++; $display("[TB] FAIL div_neg_divisor_latency got %0d want 33", rdy); end
        assertCount++;
        if (res !== 64'h00000001_FFFFFFFD) begin failCount++; $display("[TB] FAIL div_neg_divisor got %h want 00000001FFFFFFFD", res); end
        releaseStart();
    endtask

    task automatic test_div_zero();
        logic [63:0] res; int rdy; bit stOk; bit stLow;
        runDivide(1'b1, 32'd5, 32'd0, res, rdy, stOk, stLow);
        assertCount++;
        if (rdy != 2) begin failCount++; $display("[TB] FAIL divzero_latency got %0d want 2", rdy); end
        assertCount++;
        if (res !== 64'h0) begin failCount++; $display("[TB] FAIL divzero_result got %h want 0", res); end
        assertCount++;
        if (!stOk || !stLow) begin failCount++; $display("[TB] FAIL divzero_stall got ok=%b low=%b want 1 1", stOk, stLow); end
        releaseStart();
    endtask

    task automatic test_annul();
        logic [63:0] res; int rdy; bit stOk; bit stLow;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; annul = 1'b0;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        #1;
        assertCount++;
        if (stallreq !== 1'b0) begin failCount++; $display("[TB] FAIL annul_stall got %b want 0", stallreq); end
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        assertCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL annul_idle busy got %b want 0", busy); end
        assertCount++;
        if (ready !== 1'b0) begin failCount++; $display("[TB] FAIL annul_ready got %b want 0", ready); end
        assertCount++;
        if (result !== 64'h0) begin failCount++; $display("[TB] FAIL annul_result got %h want 0", result); end
        runDivide(1'b0, 32'd100, 32'd7, res, rdy, stOk, stLow);
        assertCount++;
        if (rdy != 33) begin failCount++; $display("[TB] FAIL post_annul_latency got %0d want 33", rdy); end
        assertCount++;
        if (res !== 64'h00000002_0000000E) begin failCount++; $display("[TB] FAIL post_annul_result got %h want 000000020000000E", res); end
        releaseStart();
    endtask

    task automatic test_held_start();
        logic [63:0] res; int rdy; bit stOk; bit stLow;
        runDivide(1'b0, 32'hFFFFFFFF, 32'h00000010, res, rdy, stOk, stLow);
        assertCount++;
        if (res !== 64'h0000000F_0FFFFFFF) begin failCount++; $display("[TB] FAIL held_result got %h want 0000000F0FFFFFFF", res); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            assertCount++;
            if (ready !== 1'b1 || busy !== 1'b1) begin failCount++; $display("[TB] FAIL held_ready cycle %0d got ready=%b busy=%b want 1 1", k, ready, busy); end
            assertCount++;
            if (result !== 64'h0000000F_0FFFFFFF) begin failCount++; $display("[TB] FAIL held_stable cycle %0d got %h want 0000000F0FFFFFFF", k, result); end
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        assertCount++;
        if (ready !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL held_release got ready=%b busy=%b want 0 0", ready, busy); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; int rdy; bit stOk; bit stLow;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd12345; opdata2 = 32'd6; annul = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        assertCount++;
        if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL mid_busy got %b want 1", busy); end
        #1;
        rst = 1'b1;
        #1;
        assertCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL async_reset_busy got %b want 0", busy); end
        assertCount++;
        if (result !== 64'h0) begin failCount++; $display("[TB] FAIL async_reset_result got %h want 0", result); end
        assertCount++;
        if (ready !== 1'b0) begin failCount++; $display("[TB] FAIL async_reset_ready got %b want 0", ready); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        runDivide(1'b1, 32'h80000000, 32'hFFFFFFFF, res, rdy, stOk, stLow);
        assertCount++;
        if (rdy != 33) begin failCount++; $display("[TB] FAIL overflow_latency got %0d want 33", rdy); end
        assertCount++;
        if (res !== 64'h00000000_80000000) begin failCount++; $display("[TB] FAIL overflow_result got %h want 0000000080000000", res); end
        releaseStart();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_held_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
